// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
//
// Parallel-to-serial stage feeding the single-bit input of the downstream
// serial pattern detector. WIDTH-bit words are taken in through a valid/ready
// handshake and shifted out one bit per clock. A one-word holding register
// lets the next word be taken while the current one is still shifting, so a
// continuously valid source streams with no idle cycle between words.
//
// Handshake: a word is accepted on a rising edge where i_load_valid and
// o_load_ready are both high and reset is low. o_load_ready is combinational
// (!hold_full). A source seeing o_load_ready low keeps i_data_in and
// i_load_valid stable until it is accepted.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous, active-high reset
//   i_data_in        parallel word to serialise
//   i_load_valid     i_data_in is valid this cycle
//   o_load_ready     a word can be accepted this cycle
//   o_w              serial bit to the detector (0 when o_w_valid is low)
//   o_w_valid        o_w carries a payload bit this cycle
//   o_busy           high while shifting (same as o_w_valid)
//   o_words_sent     number of fully shifted words, wraps 255 -> 0
//   o_dbg_state      current FSM state (0 = IDLE, 1 = SHIFT)
//   o_dbg_hold_full  holding register contains a pending word
// -----------------------------------------------------------------------------
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    output logic             o_w,
    output logic             o_w_valid,
    output logic             o_busy,
    output logic [7:0]       o_words_sent,
    output logic             o_dbg_state,
    output logic             o_dbg_hold_full
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   r_hr;
    logic               r_hold_full;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_words_sent;

    logic               w_accept;
    logic               w_shifting;
    logic               w_out_bit;
    logic [WIDTH-1:0]   w_sr_next;

    assign w_shifting = (r_state == S_SHIFT);
    assign w_accept   = i_load_valid && !r_hold_full;

    // The outgoing bit sits at the end the register shifts toward; zeros
    // are filled in at the opposite end.
    assign w_out_bit = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
    assign w_sr_next = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_sr[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_hr         <= '0;
            r_hold_full  <= 1'b0;
            r_cnt        <= '0;
            r_words_sent <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sr    <= i_data_in;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != CNT_LAST) begin
                        r_sr  <= w_sr_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_accept) begin
                            r_hr        <= i_data_in;
                            r_hold_full <= 1'b1;
                        end
                    end else begin
                        r_words_sent <= r_words_sent + 8'd1;
                        r_cnt        <= '0;
                        if (r_hold_full) begin
                            // load_ready is low here, so no accept can collide
                            r_sr        <= r_hr;
                            r_hold_full <= 1'b0;
                        end else if (w_accept) begin
                            // Empty hold: the new word goes straight to the
                            // shifter so streaming continues without a gap.
                            r_sr <= i_data_in;
                        end else begin
                            r_sr    <= w_sr_next;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_load_ready    = !r_hold_full;
    assign o_w_valid       = w_shifting;
    assign o_busy          = w_shifting;
    assign o_w             = w_shifting && w_out_bit;
    assign o_words_sent    = r_words_sent;
    assign o_dbg_state     = r_state;
    assign o_dbg_hold_full = r_hold_full;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_feeder
//
// Two instances (MSB-first and LSB-first) share one stimulus stream. The
// reference model treats the feeder as a bit FIFO: each accepted word appends
// its WIDTH bits in the configured order, one bit leaves per clock, and the
// block can accept whenever no more than one word's worth of bits is pending.
// -----------------------------------------------------------------------------
module tb_serial_bit_feeder;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic [W-1:0] data_in;
    logic         load_valid;

    logic         m_ready,  m_w,  m_wv,  m_busy,  m_st,  m_hf;
    logic [7:0]   m_ws;
    logic         l_ready,  l_w,  l_wv,  l_busy,  l_st,  l_hf;
    logic [7:0]   l_ws;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset(reset), .i_data_in(data_in), .i_load_valid(load_valid),
        .o_load_ready(m_ready), .o_w(m_w), .o_w_valid(m_wv), .o_busy(m_busy),
        .o_words_sent(m_ws), .o_dbg_state(m_st), .o_dbg_hold_full(m_hf)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset(reset), .i_data_in(data_in), .i_load_valid(load_valid),
        .o_load_ready(l_ready), .o_w(l_w), .o_w_valid(l_wv), .o_busy(l_busy),
        .o_words_sent(l_ws), .o_dbg_state(l_st), .o_dbg_hold_full(l_hf)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- bookkeeping ----------------
    int   checks = 0;
    int   errors = 0;
    bit   started = 0;

    logic exp_q_m[$];     // pending bits, MSB-first instance
    logic exp_q_l[$];     // pending bits, LSB-first instance
    int   exp_ws = 0;

    logic cap_m[$];       // bits observed on w while w_valid
    logic cap_l[$];
    int   run_len = 0;
    int   max_run = 0;
    bit   hf_seen = 0;
    int   ws_hist[$];
    int   prev_ws = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic q[$]);
        logic [31:0] r;
        r = '0;
        foreach (q[i]) r = {r[30:0], q[i]};
        return r;
    endfunction

    // ---------------- reference model (updates on each rising edge) ----------------
    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                exp_q_m.delete();
                exp_q_l.delete();
                exp_ws = 0;
            end else begin
                bit acc;
                acc = load_valid && (exp_q_m.size() <= W);
                if (exp_q_m.size() > 0) begin
                    // leaving bit closes a word when exactly one word-end remains
                    if (((exp_q_m.size() - 1) % W) == 0) exp_ws = (exp_ws + 1) % 256;
                    void'(exp_q_m.pop_front());
                    void'(exp_q_l.pop_front());
                end
                if (acc) begin
                    for (int i = W - 1; i >= 0; i--) exp_q_m.push_back(data_in[i]);
                    for (int i = 0; i < W; i++)      exp_q_l.push_back(data_in[i]);
                end
            end
        end
    end

    // ---------------- compare process (falling edge) ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (started) begin
                logic ev, ew_m, ew_l, er, eh;
                ev   = (exp_q_m.size() > 0);
                ew_m = ev ? exp_q_m[0] : 1'b0;
                ew_l = ev ? exp_q_l[0] : 1'b0;
                er   = (exp_q_m.size() <= W);
                eh   = (exp_q_m.size() > W);
                chk("m_w_valid", 32'(m_wv), 32'(ev));
                chk("m_w", 32'(m_w), 32'(ew_m));
                chk("m_busy", 32'(m_busy), 32'(ev));
                chk("m_load_ready", 32'(m_ready), 32'(er));
                chk("m_hold_full", 32'(m_hf), 32'(eh));
                chk("m_words_sent", 32'(m_ws), 32'(exp_ws));
                chk("l_w_valid", 32'(l_wv), 32'(ev));
                chk("l_w", 32'(l_w), 32'(ew_l));
                chk("l_load_ready", 32'(l_ready), 32'(er));
                chk("l_words_sent", 32'(l_ws), 32'(exp_ws));
                if (m_wv) cap_m.push_back(m_w);
                if (l_wv) cap_l.push_back(l_w);
                if (m_wv) run_len++; else run_len = 0;
                if (run_len > max_run) max_run = run_len;
                if (m_hf) hf_seen = 1;
                if (int'(m_ws) != prev_ws) begin
                    ws_hist.push_back(int'(m_ws));
                    prev_ws = int'(m_ws);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        load_valid = 1'b0;
        step();
        reset = 1'b0;
        cap_m.delete();
        cap_l.delete();
        run_len = 0;
        max_run = 0;
        hf_seen = 0;
        ws_hist.delete();
        prev_ws = 0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int acc_cnt;
        int guard;
        logic rdy;

        reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = '0;
        step();
        step();
        started = 1;
        reset   = 1'b0;

        // reset state
        chk("rst_w", 32'(m_w), 32'd0);
        chk("rst_w_valid", 32'(m_wv), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_ready", 32'(m_ready), 32'd1);
        chk("rst_ws", 32'(m_ws), 32'd0);

        // 1: single word A5, MSB first
        do_reset();
        data_in = 8'hA5; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (12) step();
        chk("t1_bits_m", pack(cap_m), 32'h0000_00A5);
        chk("t1_len", 32'(cap_m.size()), 32'd8);
        chk("t1_bits_l", pack(cap_l), 32'h0000_00A5);
        chk("t1_run", 32'(max_run), 32'd8);
        chk("t1_ws", 32'(m_ws), 32'd1);
        chk("t1_idle_busy", 32'(m_busy), 32'd0);
        chk("t1_idle_w", 32'(m_w), 32'd0);

        // 2: back-to-back via holding register
        do_reset();
        data_in = 8'hAA; load_valid = 1'b1;
        step();
        data_in = 8'h0F;
        step();
        chk("t2_ready_held", 32'(m_ready), 32'd0);
        chk("t2_hold_full", 32'(m_hf), 32'd1);
        load_valid = 1'b0;
        repeat (20) step();
        chk("t2_bits_m", pack(cap_m), 32'h0000_AA0F);
        chk("t2_bits_l", pack(cap_l), 32'h0000_55F0);
        chk("t2_run", 32'(max_run), 32'd16);
        chk("t2_ws", 32'(m_ws), 32'd2);

        // 3: bypass on the last bit of a word
        do_reset();
        data_in = 8'hAA; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (7) step();
        chk("t3_ready_last", 32'(m_ready), 32'd1);
        data_in = 8'h0A; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (12) step();
        chk("t3_bits_m", pack(cap_m), 32'h0000_AA0A);
        chk("t3_run", 32'(max_run), 32'd16);
        chk("t3_hf_seen", 32'(hf_seen), 32'd0);
        chk("t3_ws", 32'(m_ws), 32'd2);

        // 4: reset mid-word with a held word pending
        do_reset();
        data_in = 8'hFF; load_valid = 1'b1;
        step();
        data_in = 8'h3C;
        step();
        load_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_bits_before", 32'(cap_m.size()), 32'd3);
        chk("t4_w", 32'(m_w), 32'd0);
        chk("t4_w_valid", 32'(m_wv), 32'd0);
        chk("t4_ready", 32'(m_ready), 32'd1);
        chk("t4_ws", 32'(m_ws), 32'd0);
        cap_m.delete();
        repeat (12) step();
        chk("t4_no_emit", 32'(cap_m.size()), 32'd0);
        chk("t4_ws_after", 32'(m_ws), 32'd0);

        // 5: LSB-first instance with 8'h01
        do_reset();
        data_in = 8'h01; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (12) step();
        chk("t5_bits_l", pack(cap_l), 32'h0000_0080);
        chk("t5_bits_m", pack(cap_m), 32'h0000_0001);

        // 6: 257 words streamed continuously, counter wrap
        do_reset();
        acc_cnt = 0;
        guard   = 0;
        load_valid = 1'b1;
        while (acc_cnt < 257 && guard < 4000) begin
            data_in = 8'(acc_cnt * 37 + 1);
            rdy = m_ready;
            step();
            if (rdy) acc_cnt++;
            guard++;
        end
        load_valid = 1'b0;
        repeat (20) step();
        chk("t6_accepted", 32'(acc_cnt), 32'd257);
        chk("t6_hist_len", 32'(ws_hist.size()), 32'd257);
        if (ws_hist.size() == 257) begin
            chk("t6_ws_255", 32'(ws_hist[254]), 32'd255);
            chk("t6_ws_0", 32'(ws_hist[255]), 32'd0);
            chk("t6_ws_1", 32'(ws_hist[256]), 32'd1);
        end
        chk("t6_run", 32'(max_run), 32'd2056);
        chk("t6_ws_final", 32'(m_ws), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
Parallel-to-serial stage that sits directly upstream of the serial pattern-detector FSM and drives its single-bit input w, one bit per clock.
Accepts WIDTH-bit words through a valid/ready handshake and shifts each word out in a fixed bit order.
A one-word holding register allows back-to-back words to stream with no idle cycle between them.
w_valid marks the cycles in which w carries payload; the downstream detector is clock-enabled or qualified by w_valid.

Parameters:
WIDTH, 8, word width in bits (2..32).
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  parallel word to serialise
load_valid  input  1  data_in is valid this cycle
load_ready  output  1  block can accept a word this cycle (combinational: !hold_full)
w  output  1  serial bit to the downstream detector (forced 0 when w_valid=0)
w_valid  output  1  w carries a payload bit this cycle
busy  output  1  high while in SHIFT state
words_sent  output  8  count of fully shifted words, wraps 255->0

Behaviour:
- Accept = load_valid && load_ready at a rising edge with reset=0. load_valid while load_ready=0 is ignored; the source holds data.
- Internal state: shift register sr[WIDTH], bit counter cnt (0..WIDTH-1), holding register hr[WIDTH], hold_full flag, FSM {IDLE, SHIFT}.
- Reset (synchronous, wins over everything): state=IDLE, sr=0, hr=0, hold_full=0, cnt=0, words_sent=0. Outputs then: w=0, w_valid=0, busy=0, load_ready=1. Accept is ignored during a reset cycle.
- Output bit is sr[WIDTH-1] when MSB_FIRST=1, or sr[0] when MSB_FIRST=0.
- w_valid = busy = (state==SHIFT). Both are decoded directly from registered state and do not depend on any input.
- IDLE:
  - On accept: sr<=data_in, cnt<=0, state<=SHIFT.
  - The first bit appears on w in the cycle after the accept edge, so latency is 1 cycle.
  - hold_full is always 0 in IDLE.
- SHIFT, edge with cnt<WIDTH-1:
  - sr shifts by one in the configured direction, with 0 filled in; cnt<=cnt+1.
  - If accept: hr<=data_in, hold_full<=1.
- SHIFT, edge with cnt==WIDTH-1 (last bit of the word):
  - words_sent<=words_sent+1 (mod 256); cnt<=0.
  - If hold_full: sr<=hr, hold_full<=0, stay in SHIFT. No accept is possible on this edge because load_ready=0.
  - Else if accept: sr<=data_in, stay in SHIFT. The word bypasses hr.
  - Else: state<=IDLE.
- Continuous streaming: with the source always valid, w_valid stays high indefinitely with no gap cycles between words.
- Reset mid-word: the partial word and any held word are discarded, words_sent is cleared, and w drops to 0 on the next cycle.
- WIDTH-bit words only; there are no partial words.

Test Plan:
1. MSB_FIRST=1, WIDTH=8: accept 8'hA5 at edge 0, then load_valid=0 → w = 1,0,1,0,0,1,0,1 in cycles 1..8; w_valid high exactly cycles 1..8; words_sent=1; busy=0 and w=0 from cycle 9.
2. Back-to-back: offer 8'hAA, then 8'h0F while shifting → the second word is accepted into hr and load_ready=0 until the first word's last bit; 16 contiguous w_valid cycles with w = 10101010 00001111; words_sent=2.
3. Bypass on last bit: hold empty, offer 8'h0A exactly at the edge with cnt==7 → load_ready=1, the word loads directly into sr, there is no w_valid gap, and hold_full stays 0.
4. Reset mid-word: assert reset for one cycle after 3 bits of 8'hFF, with a held word pending → next cycle w=0, w_valid=0, load_ready=1, words_sent=0; the held word is never emitted.
5. MSB_FIRST=0: accept 8'h01 → w = 1,0,0,0,0,0,0,0.
6. Stream 257 words continuously → words_sent reads 255 then 0 then 1; w_valid never deasserts during the stream.
